// File: rtl/pulse_counter_bank_pkg.sv
// pulse_counter_bank_pkg
//   Shared definitions for the pulse counter bank:
//   - mode_e : overflow behaviour selected by sat_mode_in (wrap / saturate)
//   - clog2  : ceiling log2, used to size the debounce counters
package pulse_counter_bank_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pulse_counter_bank_if.sv
// pulse_counter_bank_if
//   Groups the control, button and result signals of pulse_counter_bank.
//   master : driver side (board/test environment)
//   slave  : pulse_counter_bank side
//   Signals:
//     en_in       global count enable
//     sat_mode_in 0 = wrap on overflow, 1 = saturate at all-ones
//     clr_in      per-channel synchronous clear
//     btn_in      raw asynchronous button levels
//     count_out   flattened counters, channel i at [i*COUNT_W +: COUNT_W]
//     ovf_out     sticky per-channel overflow flags
//     press_out   one-cycle pulse per accepted rising edge
interface pulse_counter_bank_if #(
    parameter int unsigned N_CHANNELS = 4,
    parameter int unsigned COUNT_W    = 4
);
    logic                            en_in;
    logic                            sat_mode_in;
    logic [N_CHANNELS-1:0]           clr_in;
    logic [N_CHANNELS-1:0]           btn_in;
    logic [N_CHANNELS*COUNT_W-1:0]   count_out;
    logic [N_CHANNELS-1:0]           ovf_out;
    logic [N_CHANNELS-1:0]           press_out;

    modport master (
        output en_in, sat_mode_in, clr_in, btn_in,
        input  count_out, ovf_out, press_out
    );

    modport slave (
        input  en_in, sat_mode_in, clr_in, btn_in,
        output count_out, ovf_out, press_out
    );
endinterface

// File: rtl/pulse_counter_bank_conditioner.sv
// pulse_conditioner
//   One button channel: 2-FF synchronizer, debouncer and rising-edge detect.
//   Ports:
//     clk, rst  clock / asynchronous active-high reset
//     btn_in    raw asynchronous button level
//     press_out combinational pulse in the cycle the accepted level rises;
//               the counter bank updates on the same edge and registers it
//               for its own press_out
module pulse_conditioner
    import pulse_counter_bank_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic press_out
);
    localparam int unsigned      DB_W    = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            s1;
    logic            s2;
    logic            stable;
    logic [DB_W-1:0] db_cnt;
    logic [1:0]      fill;
    logic            armed;

    // A press is only reported once a genuine low has been seen after reset.
    // fill marks when s2 holds a real sample rather than its reset value, so a
    // button held across reset release raises stable silently and must be
    // released and pressed again before it counts.
    assign press_out = (s2 != stable) && s2 && (db_cnt == DB_LAST) && armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            db_cnt <= '0;
            fill   <= '0;
            armed  <= 1'b0;
        end else begin
            s1   <= btn_in;
            s2   <= s1;
            fill <= {fill[0], 1'b1};
            if (fill[1] && !s2 && !stable) begin
                armed <= 1'b1;
            end
            if (s2 == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                stable <= s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end
endmodule

// File: rtl/pulse_counter_bank.sv
// pulse_counter_bank
//   N independent debounced button counters with wrap/saturate overflow,
//   per-channel clear, global enable and sticky overflow flags.
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous active-high reset
//     bus  pulse_counter_bank_if.slave: en_in, sat_mode_in, clr_in, btn_in,
//          count_out, ovf_out, press_out
module pulse_counter_bank
    import pulse_counter_bank_pkg::*;
#(
    parameter int unsigned N_CHANNELS      = 4,
    parameter int unsigned COUNT_W         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    pulse_counter_bank_if.slave bus
);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic [N_CHANNELS-1:0]          press;
    logic [N_CHANNELS-1:0]          press_q;
    logic [N_CHANNELS-1:0]          ovf;
    logic [COUNT_W-1:0]             cnt [N_CHANNELS];
    logic [N_CHANNELS*COUNT_W-1:0]  count_flat;
    mode_e                          mode;

    assign mode = mode_e'(bus.sat_mode_in);

    for (genvar g = 0; g < N_CHANNELS; g++) begin : g_ch
        pulse_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cond (
            .clk       (clk),
            .rst       (rst),
            .btn_in    (bus.btn_in[g]),
            .press_out (press[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_q <= '0;
            ovf     <= '0;
            for (int unsigned i = 0; i < N_CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            press_q <= press;
            for (int unsigned i = 0; i < N_CHANNELS; i++) begin
                if (bus.clr_in[i]) begin
                    cnt[i] <= '0;
                    ovf[i] <= 1'b0;
                end else if (press[i] && bus.en_in) begin
                    if (cnt[i] != CNT_MAX) begin
                        cnt[i] <= cnt[i] + COUNT_W'(1);
                    end else begin
                        ovf[i] <= 1'b1;
                        if (mode == MODE_WRAP) begin
                            cnt[i] <= '0;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        count_flat = '0;
        for (int unsigned i = 0; i < N_CHANNELS; i++) begin
            count_flat[i*COUNT_W +: COUNT_W] = cnt[i];
        end
    end

    assign bus.count_out = count_flat;
    assign bus.ovf_out   = ovf;
    assign bus.press_out = press_q;
endmodule

// File: tb/tb_pulse_counter_bank.sv
// tb_pulse_counter_bank
//   Directed self-checking bench for pulse_counter_bank (4 channels, 4-bit
//   counters, 4-cycle debounce). Inputs change and outputs are sampled on the
//   falling clock edge.
module tb_pulse_counter_bank;
    localparam int unsigned N = 4;
    localparam int unsigned W = 4;
    localparam int unsigned D = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   press_cnt [N];

    always #5 clk = ~clk;

    pulse_counter_bank_if #(.N_CHANNELS(N), .COUNT_W(W)) bus ();

    pulse_counter_bank #(
        .N_CHANNELS      (N),
        .COUNT_W         (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (bus.press_out[i] === 1'b1) press_cnt[i]++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [N-1:0] mask);
        bus.btn_in = bus.btn_in | mask;
        cycles(8);
        bus.btn_in = bus.btn_in & ~mask;
        cycles(8);
    endtask

    task automatic clear_press_cnt();
        for (int i = 0; i < N; i++) press_cnt[i] = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en_in = 1'b1;
        bus.sat_mode_in = 1'b0;
        bus.clr_in = '0;
        bus.btn_in = '0;
        clear_press_cnt();
        cycles(2);
        checks++;
        if (bus.count_out !== 16'h0000) begin
            errors++; $display("FAIL reset_count: got %h expected 0000", bus.count_out);
        end
        checks++;
        if (bus.ovf_out !== 4'h0) begin
            errors++; $display("FAIL reset_ovf: got %b expected 0000", bus.ovf_out);
        end
        checks++;
        if (bus.press_out !== 4'h0) begin
            errors++; $display("FAIL reset_press: got %b expected 0000", bus.press_out);
        end
        rst = 1'b0;
        cycles(5);
    endtask

    task automatic test_latency();
        logic [15:0] c;
        bus.btn_in[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            c = bus.count_out;
            checks++;
            if (c[3:0] !== 4'd0) begin
                errors++; $display("FAIL latency_early[%0d]: got %0d expected 0", i, c[3:0]);
            end
        end
        @(negedge clk);
        c = bus.count_out;
        checks++;
        if (c[3:0] !== 4'd1) begin
            errors++; $display("FAIL latency_count: got %0d expected 1", c[3:0]);
        end
        checks++;
        if (bus.press_out !== 4'b0001) begin
            errors++; $display("FAIL latency_press_hi: got %b expected 0001", bus.press_out);
        end
        @(negedge clk);
        checks++;
        if (bus.press_out !== 4'b0000) begin
            errors++; $display("FAIL latency_press_lo: got %b expected 0000", bus.press_out);
        end
        cycles(43);
        bus.btn_in[0] = 1'b0;
        cycles(12);
        checks++;
        if (bus.count_out !== 16'h0001) begin
            errors++; $display("FAIL hold_count: got %h expected 0001", bus.count_out);
        end
        checks++;
        if (press_cnt[0] !== 1) begin
            errors++; $display("FAIL hold_press_pulses: got %0d expected 1", press_cnt[0]);
        end
    endtask

    task automatic test_glitch();
        repeat (10) begin
            bus.btn_in[1] = 1'b1;
            cycles(3);
            bus.btn_in[1] = 1'b0;
            cycles(3);
        end
        cycles(10);
        checks++;
        if (bus.count_out !== 16'h0001) begin
            errors++; $display("FAIL glitch_count: got %h expected 0001", bus.count_out);
        end
        checks++;
        if (press_cnt[1] !== 0) begin
            errors++; $display("FAIL glitch_press: got %0d expected 0", press_cnt[1]);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] c;
        bus.sat_mode_in = 1'b0;
        for (int p = 1; p <= 17; p++) begin
            press(4'b0100);
            c = bus.count_out;
            if (p == 15) begin
                checks++;
                if (c[11:8] !== 4'd15 || bus.ovf_out[2] !== 1'b0) begin
                    errors++; $display("FAIL wrap_15: got cnt %0d ovf %b expected 15 0", c[11:8], bus.ovf_out[2]);
                end
            end
            if (p == 16) begin
                checks++;
                if (c[11:8] !== 4'd0 || bus.ovf_out[2] !== 1'b1) begin
                    errors++; $display("FAIL wrap_16: got cnt %0d ovf %b expected 0 1", c[11:8], bus.ovf_out[2]);
                end
            end
        end
        checks++;
        if (bus.count_out !== 16'h0101) begin
            errors++; $display("FAIL wrap_17_count: got %h expected 0101", bus.count_out);
        end
        checks++;
        if (bus.ovf_out !== 4'b0100) begin
            errors++; $display("FAIL wrap_17_ovf: got %b expected 0100", bus.ovf_out);
        end
    endtask

    task automatic test_sat_clear();
        logic [15:0] c;
        bus.sat_mode_in = 1'b1;
        repeat (20) press(4'b1000);
        c = bus.count_out;
        checks++;
        if (c[15:12] !== 4'd15 || bus.ovf_out[3] !== 1'b1) begin
            errors++; $display("FAIL sat_20: got cnt %0d ovf %b expected 15 1", c[15:12], bus.ovf_out[3]);
        end
        bus.sat_mode_in = 1'b0;
        cycles(2);
        c = bus.count_out;
        checks++;
        if (c[15:12] !== 4'd15) begin
            errors++; $display("FAIL sat_mode_change: got %0d expected 15", c[15:12]);
        end
        bus.sat_mode_in = 1'b1;
        bus.btn_in[3] = 1'b1;
        cycles(5);
        bus.clr_in[3] = 1'b1;
        @(negedge clk);
        bus.clr_in[3] = 1'b0;
        c = bus.count_out;
        checks++;
        if (bus.press_out[3] !== 1'b1) begin
            errors++; $display("FAIL clr_press_seen: got %b expected 1", bus.press_out[3]);
        end
        checks++;
        if (c[15:12] !== 4'd0 || bus.ovf_out[3] !== 1'b0) begin
            errors++; $display("FAIL clr_wins: got cnt %0d ovf %b expected 0 0", c[15:12], bus.ovf_out[3]);
        end
        cycles(2);
        bus.btn_in[3] = 1'b0;
        cycles(8);
        checks++;
        if (bus.count_out !== 16'h0101 || bus.ovf_out !== 4'b0100) begin
            errors++; $display("FAIL clr_after: got %h/%b expected 0101/0100", bus.count_out, bus.ovf_out);
        end
    endtask

    task automatic test_enable_concurrency();
        bus.clr_in = '1;
        @(negedge clk);
        bus.clr_in = '0;
        checks++;
        if (bus.count_out !== 16'h0000 || bus.ovf_out !== 4'b0000) begin
            errors++; $display("FAIL clear_all: got %h/%b expected 0000/0000", bus.count_out, bus.ovf_out);
        end
        clear_press_cnt();
        bus.en_in = 1'b0;
        repeat (3) press(4'hF);
        checks++;
        if (bus.count_out !== 16'h0000) begin
            errors++; $display("FAIL en_off: got %h expected 0000", bus.count_out);
        end
        bus.en_in = 1'b1;
        repeat (2) press(4'hF);
        checks++;
        if (bus.count_out !== 16'h2222) begin
            errors++; $display("FAIL en_on: got %h expected 2222", bus.count_out);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (press_cnt[i] !== 5) begin
                errors++; $display("FAIL press_pulses[%0d]: got %0d expected 5", i, press_cnt[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [N-1:0] mask;
        bus.clr_in = '1;
        @(negedge clk);
        bus.clr_in = '0;
        bus.sat_mode_in = 1'b0;
        for (int p = 0; p < 4; p++) begin
            mask = 4'b0001;
            if (p < 3) mask[1] = 1'b1;
            if (p < 2) mask[2] = 1'b1;
            if (p < 1) mask[3] = 1'b1;
            press(mask);
        end
        checks++;
        if (bus.count_out !== 16'h1234 || bus.ovf_out !== 4'b0000) begin
            errors++; $display("FAIL pre_reset: got %h/%b expected 1234/0000", bus.count_out, bus.ovf_out);
        end
        clear_press_cnt();
        bus.btn_in[0] = 1'b1;
        cycles(3);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.count_out !== 16'h0000 || bus.ovf_out !== 4'b0000 || bus.press_out !== 4'b0000) begin
            errors++; $display("FAIL async_reset: got %h/%b/%b expected 0000/0000/0000",
                               bus.count_out, bus.ovf_out, bus.press_out);
        end
        #3;
        rst = 1'b0;
        cycles(20);
        checks++;
        if (bus.count_out !== 16'h0000 || press_cnt[0] !== 0) begin
            errors++; $display("FAIL held_through_reset: got %h pulses %0d expected 0000 0",
                               bus.count_out, press_cnt[0]);
        end
        bus.btn_in[0] = 1'b0;
        cycles(12);
        press(4'b0001);
        checks++;
        if (bus.count_out !== 16'h0001 || press_cnt[0] !== 1) begin
            errors++; $display("FAIL repress_after_reset: got %h pulses %0d expected 0001 1",
                               bus.count_out, press_cnt[0]);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_wrap();
        test_sat_clear();
        test_enable_concurrency();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
